booth_seq_ctrl: RTL



---
 rtl/booth_seq_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/booth_seq_ctrl.sv
// Iterative radix-4 Booth multiplier controller: scans the multiplier two bits per
// cycle, drives an external partial-product generator and accumulates a 2W-bit product.
module booth_seq_ctrl #(
    parameter int W      = 16,
    parameter int PP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic [W-1:0]     pp_y,
    output logic [2:0]       booth_bits,
    input  logic [W:0]       pp,
    input  logic             cpl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // RUN   | issuing Booth triplets and accumulating returned partial products
    // DONE  | product held, out_valid high until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N       = W / 2;
    localparam int RUN_CYC = N + PP_LAT;
    localparam int CW      = $clog2(RUN_CYC);
    localparam int KW      = $clog2(N);

    state_t           state_q, state_d;
    logic             ready_en_q;
    logic [CW-1:0]    cnt_q;
    logic [W:0]       xs_q;
    logic [KW-1:0]    k_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   term;
    logic [2*W-1:0]   acc_d;
    logic             accept;
    logic             issue;
    logic             accum;
    logic             last;

    // cnt_q runs down from RUN_CYC-1; with a pipelined generator the first RUN
    // cycle returns nothing yet and the last RUN cycle issues nothing.
    assign issue  = (state_q == RUN) && ((PP_LAT == 0) || (cnt_q != '0));
    assign accum  = (state_q == RUN) && ((PP_LAT == 0) || (cnt_q != CW'(RUN_CYC - 1)));
    assign last   = (cnt_q == '0);
    assign accept = (state_q == IDLE) && in_valid && ready_en_q;

    assign booth_bits = issue ? xs_q[2:0] : 3'b000;

    assign term  = {{(W-1){pp[W]}}, pp} + {{(2*W-1){1'b0}}, cpl};
    assign acc_d = acc_q + (term << {k_q, 1'b0});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ready_en_q;
                if (in_valid && ready_en_q) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ready_en_q keeps in_ready low until the first clock after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            cnt_q      <= '0;
            xs_q       <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            pp_y       <= '0;
            product    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                xs_q  <= {x, 1'b0};
                pp_y  <= y;
                acc_q <= '0;
                k_q   <= '0;
                cnt_q <= CW'(RUN_CYC - 1);
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q - 1'b1;
                if (issue) xs_q <= {2'b00, xs_q[W:2]};
                if (accum) begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 1'b1;
                end
                if (last) product <= acc_d;
            end
        end
    end

endmodule
